// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: ALU control encodings, ID/EX select codes,
// default datapath width and the ALU control derivation used in decode.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT      = 32;
    localparam int unsigned REGADDR_W_DEFAULT = 5;

    // ALU control encodings as consumed by the alu block
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Instruction class driving the ALU control derivation
    localparam logic [1:0] OPK_R     = 2'b00;
    localparam logic [1:0] OPK_I     = 2'b01;
    localparam logic [1:0] OPK_OTHER = 2'b10;

    // Operand A select
    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    // Operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // funct3 of the shift-right group, the only I-type whose bit 30 matters
    localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

    // Derive the 4-bit ALU control code from the decoded instruction fields.
    // For I-type, bit 30 belongs to the immediate except for SRLI/SRAI.
    function automatic logic [3:0] alu_ctrl(
        input logic [1:0] op_kind,
        input logic [2:0] funct3,
        input logic       funct7b5
    );
        logic [3:0] ctrl;
        ctrl = ALU_ADD;
        case (op_kind)
            OPK_R:   ctrl = {funct7b5, funct3};
            OPK_I:   ctrl = (funct3 == F3_SHIFT_RIGHT) ? {funct7b5, funct3}
                                                       : {1'b0, funct3};
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/idex_stage_fwd_mux.sv
// Operand forwarding for one source register: picks the EX/MEM result, then
// the MEM/WB result, then the registered value. x0 is never forwarded.
module fwd_mux #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REGADDR_W = 5
) (
    input  logic [REGADDR_W-1:0] rs_addr_i,
    input  logic [XLEN-1:0]      reg_data_i,
    input  logic                 exmem_regwrite_i,
    input  logic [REGADDR_W-1:0] exmem_rd_addr_i,
    input  logic [XLEN-1:0]      exmem_result_i,
    input  logic                 memwb_regwrite_i,
    input  logic [REGADDR_W-1:0] memwb_rd_addr_i,
    input  logic [XLEN-1:0]      memwb_result_i,
    output logic [XLEN-1:0]      data_o
);

    logic rs_nonzero;
    logic exmem_hit;
    logic memwb_hit;

    assign rs_nonzero = (rs_addr_i != '0);
    assign exmem_hit  = exmem_regwrite_i && rs_nonzero && (exmem_rd_addr_i == rs_addr_i);
    assign memwb_hit  = memwb_regwrite_i && rs_nonzero && (memwb_rd_addr_i == rs_addr_i);

    // Priority select: the younger producer (EX/MEM) wins over MEM/WB
    always_comb begin
        data_o = reg_data_i;
        if (exmem_hit) begin
            data_o = exmem_result_i;
        end else if (memwb_hit) begin
            data_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register of the RV32I core. Registers decoded fields and the
// ALU control code, then forwards and muxes the operands presented to the ALU.
module idex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEFAULT,
    parameter int unsigned REGADDR_W = REGADDR_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 id_valid_i,
    input  logic [XLEN-1:0]      id_pc_i,
    input  logic [XLEN-1:0]      id_imm_i,
    input  logic [XLEN-1:0]      id_rs1_data_i,
    input  logic [XLEN-1:0]      id_rs2_data_i,
    input  logic [REGADDR_W-1:0] id_rs1_addr_i,
    input  logic [REGADDR_W-1:0] id_rs2_addr_i,
    input  logic [REGADDR_W-1:0] id_rd_addr_i,
    input  logic                 id_regwrite_i,
    input  logic [2:0]           id_funct3_i,
    input  logic                 id_funct7b5_i,
    input  logic [1:0]           id_op_kind_i,
    input  logic [1:0]           id_src_a_i,
    input  logic [1:0]           id_src_b_i,
    input  logic                 exmem_regwrite_i,
    input  logic [REGADDR_W-1:0] exmem_rd_addr_i,
    input  logic [XLEN-1:0]      exmem_result_i,
    input  logic                 memwb_regwrite_i,
    input  logic [REGADDR_W-1:0] memwb_rd_addr_i,
    input  logic [XLEN-1:0]      memwb_result_i,
    output logic                 ex_valid_o,
    output logic [XLEN-1:0]      alu_a_o,
    output logic [XLEN-1:0]      alu_b_o,
    output logic [3:0]           aluctrl_o,
    output logic [XLEN-1:0]      ex_store_data_o,
    output logic [REGADDR_W-1:0] ex_rd_addr_o,
    output logic                 ex_regwrite_o
);

    logic                 valid_q,    valid_d;
    logic [XLEN-1:0]      pc_q,       pc_d;
    logic [XLEN-1:0]      imm_q,      imm_d;
    logic [XLEN-1:0]      rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]      rs2_data_q, rs2_data_d;
    logic [REGADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [REGADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [REGADDR_W-1:0] rd_addr_q,  rd_addr_d;
    logic                 regwrite_q, regwrite_d;
    logic [3:0]           aluctrl_q,  aluctrl_d;
    logic [1:0]           src_a_q,    src_a_d;
    logic [1:0]           src_b_q,    src_b_d;

    logic [XLEN-1:0]      rs1_fwd;
    logic [XLEN-1:0]      rs2_fwd;

    fwd_mux #(
        .XLEN      (XLEN),
        .REGADDR_W (REGADDR_W)
    ) u_fwd_rs1 (
        .rs_addr_i        (rs1_addr_q),
        .reg_data_i       (rs1_data_q),
        .exmem_regwrite_i (exmem_regwrite_i),
        .exmem_rd_addr_i  (exmem_rd_addr_i),
        .exmem_result_i   (exmem_result_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .memwb_rd_addr_i  (memwb_rd_addr_i),
        .memwb_result_i   (memwb_result_i),
        .data_o           (rs1_fwd)
    );

    fwd_mux #(
        .XLEN      (XLEN),
        .REGADDR_W (REGADDR_W)
    ) u_fwd_rs2 (
        .rs_addr_i        (rs2_addr_q),
        .reg_data_i       (rs2_data_q),
        .exmem_regwrite_i (exmem_regwrite_i),
        .exmem_rd_addr_i  (exmem_rd_addr_i),
        .exmem_result_i   (exmem_result_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .memwb_rd_addr_i  (memwb_rd_addr_i),
        .memwb_result_i   (memwb_result_i),
        .data_o           (rs2_fwd)
    );

    // Next-state selection: flush beats stall, stall holds fields but captures
    // forwarded operand data so a producer retiring mid-stall is not lost
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        regwrite_d = regwrite_q;
        aluctrl_d  = aluctrl_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        if (flush_i || (!stall_i && !id_valid_i)) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            imm_d      = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_addr_d  = '0;
            regwrite_d = 1'b0;
            aluctrl_d  = ALU_ADD;
            src_a_d    = SRCA_RS1;
            src_b_d    = SRCB_RS2;
        end else if (stall_i) begin
            rs1_data_d = rs1_fwd;
            rs2_data_d = rs2_fwd;
        end else begin
            valid_d    = 1'b1;
            pc_d       = id_pc_i;
            imm_d      = id_imm_i;
            rs1_data_d = id_rs1_data_i;
            rs2_data_d = id_rs2_data_i;
            rs1_addr_d = id_rs1_addr_i;
            rs2_addr_d = id_rs2_addr_i;
            rd_addr_d  = id_rd_addr_i;
            regwrite_d = id_regwrite_i;
            aluctrl_d  = alu_ctrl(id_op_kind_i, id_funct3_i, id_funct7b5_i);
            src_a_d    = id_src_a_i;
            src_b_d    = id_src_b_i;
        end
    end

    // Stage register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            regwrite_q <= 1'b0;
            aluctrl_q  <= ALU_ADD;
            src_a_q    <= SRCA_RS1;
            src_b_q    <= SRCB_RS2;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            regwrite_q <= regwrite_d;
            aluctrl_q  <= aluctrl_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
        end
    end

    // Operand muxes after forwarding; select code 11 falls back to the register
    always_comb begin
        case (src_a_q)
            SRCA_PC:   alu_a_o = pc_q;
            SRCA_ZERO: alu_a_o = '0;
            default:   alu_a_o = rs1_fwd;
        endcase
        case (src_b_q)
            SRCB_IMM:  alu_b_o = imm_q;
            SRCB_FOUR: alu_b_o = XLEN'(4);
            default:   alu_b_o = rs2_fwd;
        endcase
    end

    assign aluctrl_o       = aluctrl_q;
    assign ex_valid_o      = valid_q;
    assign ex_store_data_o = rs2_fwd;
    assign ex_rd_addr_o    = rd_addr_q;
    assign ex_regwrite_o   = regwrite_q && valid_q;

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage: directed test-plan steps followed by a
// randomized run checked against a behavioural model of the stage contents.
module tb_idex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        id_valid_i = 1'b0;
    logic [31:0] id_pc_i = '0, id_imm_i = '0, id_rs1_data_i = '0, id_rs2_data_i = '0;
    logic [4:0]  id_rs1_addr_i = '0, id_rs2_addr_i = '0, id_rd_addr_i = '0;
    logic        id_regwrite_i = 1'b0;
    logic [2:0]  id_funct3_i = '0;
    logic        id_funct7b5_i = 1'b0;
    logic [1:0]  id_op_kind_i = '0, id_src_a_i = '0, id_src_b_i = '0;
    logic        exmem_regwrite_i = 1'b0;
    logic [4:0]  exmem_rd_addr_i = '0;
    logic [31:0] exmem_result_i = '0;
    logic        memwb_regwrite_i = 1'b0;
    logic [4:0]  memwb_rd_addr_i = '0;
    logic [31:0] memwb_result_i = '0;
    logic        ex_valid_o;
    logic [31:0] alu_a_o, alu_b_o, ex_store_data_o;
    logic [3:0]  aluctrl_o;
    logic [4:0]  ex_rd_addr_o;
    logic        ex_regwrite_o;

    int compared   = 0;
    int mismatched = 0;

    idex_stage #(.XLEN(32), .REGADDR_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .id_valid_i       (id_valid_i),
        .id_pc_i          (id_pc_i),
        .id_imm_i         (id_imm_i),
        .id_rs1_data_i    (id_rs1_data_i),
        .id_rs2_data_i    (id_rs2_data_i),
        .id_rs1_addr_i    (id_rs1_addr_i),
        .id_rs2_addr_i    (id_rs2_addr_i),
        .id_rd_addr_i     (id_rd_addr_i),
        .id_regwrite_i    (id_regwrite_i),
        .id_funct3_i      (id_funct3_i),
        .id_funct7b5_i    (id_funct7b5_i),
        .id_op_kind_i     (id_op_kind_i),
        .id_src_a_i       (id_src_a_i),
        .id_src_b_i       (id_src_b_i),
        .exmem_regwrite_i (exmem_regwrite_i),
        .exmem_rd_addr_i  (exmem_rd_addr_i),
        .exmem_result_i   (exmem_result_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .memwb_rd_addr_i  (memwb_rd_addr_i),
        .memwb_result_i   (memwb_result_i),
        .ex_valid_o       (ex_valid_o),
        .alu_a_o          (alu_a_o),
        .alu_b_o          (alu_b_o),
        .aluctrl_o        (aluctrl_o),
        .ex_store_data_o  (ex_store_data_o),
        .ex_rd_addr_o     (ex_rd_addr_o),
        .ex_regwrite_o    (ex_regwrite_o)
    );

    always #5 clk = ~clk;

    // Model of the instruction currently held in EX (a bubble is all zeros)
    typedef struct {
        logic        valid;
        logic [31:0] pc, imm, rs1d, rs2d;
        logic [4:0]  rs1a, rs2a, rd;
        logic        rw;
        logic [2:0]  f3;
        logic        f7;
        logic [1:0]  kind, sa, sb;
    } ex_t;

    ex_t m;

    function automatic ex_t bubble();
        ex_t b;
        b.valid = 0; b.pc = 0; b.imm = 0; b.rs1d = 0; b.rs2d = 0;
        b.rs1a = 0; b.rs2a = 0; b.rd = 0; b.rw = 0; b.f3 = 0; b.f7 = 0;
        b.kind = 0; b.sa = 0; b.sb = 0;
        return b;
    endfunction

    // Value an EX operand sees given the current forward sources
    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
        if (a != 0 && exmem_regwrite_i && exmem_rd_addr_i == a) return exmem_result_i;
        if (a != 0 && memwb_regwrite_i && memwb_rd_addr_i == a) return memwb_result_i;
        return d;
    endfunction

    function automatic int exp_ctrl(input ex_t e);
        if (e.kind == 2'd0) return int'(e.f7) * 8 + int'(e.f3);
        if (e.kind == 2'd1) return (e.f3 == 3'd5) ? int'(e.f7) * 8 + 5 : int'(e.f3);
        return 0;
    endfunction

    function automatic logic [31:0] exp_a(input ex_t e);
        if (e.sa == 2'd1) return e.pc;
        if (e.sa == 2'd2) return 32'd0;
        return fwd(e.rs1a, e.rs1d);
    endfunction

    function automatic logic [31:0] exp_b(input ex_t e);
        if (e.sb == 2'd1) return e.imm;
        if (e.sb == 2'd2) return 32'd4;
        return fwd(e.rs2a, e.rs2d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid",    32'(ex_valid_o),    32'(m.valid));
        chk("regwrite", 32'(ex_regwrite_o), 32'(m.valid & m.rw));
        chk("rd",       32'(ex_rd_addr_o),  32'(m.rd));
        chk("aluctrl",  32'(aluctrl_o),     32'(exp_ctrl(m)));
        chk("alu_a",    alu_a_o,            exp_a(m));
        chk("alu_b",    alu_b_o,            exp_b(m));
        chk("store",    ex_store_data_o,    fwd(m.rs2a, m.rs2d));
    endtask

    // Advance one clock: model next contents from inputs seen at the edge
    task automatic step();
        ex_t n;
        n = m;
        if (rst || flush_i) n = bubble();
        else if (stall_i) begin
            n.rs1d = fwd(m.rs1a, m.rs1d);
            n.rs2d = fwd(m.rs2a, m.rs2d);
        end else if (!id_valid_i) n = bubble();
        else begin
            n.valid = 1; n.pc = id_pc_i; n.imm = id_imm_i;
            n.rs1d = id_rs1_data_i; n.rs2d = id_rs2_data_i;
            n.rs1a = id_rs1_addr_i; n.rs2a = id_rs2_addr_i; n.rd = id_rd_addr_i;
            n.rw = id_regwrite_i; n.f3 = id_funct3_i; n.f7 = id_funct7b5_i;
            n.kind = id_op_kind_i; n.sa = id_src_a_i; n.sb = id_src_b_i;
        end
        @(posedge clk);
        #1;
        m = n;
        check_all();
    endtask

    task automatic no_fwd();
        exmem_regwrite_i = 0; exmem_rd_addr_i = 0; exmem_result_i = 0;
        memwb_regwrite_i = 0; memwb_rd_addr_i = 0; memwb_result_i = 0;
    endtask

    task automatic set_id(input logic [1:0] kind, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [1:0] sa, input logic [1:0] sb);
        id_valid_i = 1; id_op_kind_i = kind; id_funct3_i = f3; id_funct7b5_i = f7;
        id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rd_addr_i = rd;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
        id_src_a_i = sa; id_src_b_i = sb; id_regwrite_i = 1; id_pc_i = 32'h100;
    endtask

    initial begin
        m = bubble();
        // Reset state
        rst = 1;
        step();
        step();
        chk("rst_valid", 32'(ex_valid_o), 32'd0);
        chk("rst_ctrl", 32'(aluctrl_o), 32'd0);
        chk("rst_a", alu_a_o, 32'd0);
        rst = 0;

        // R-type SUB
        set_id(2'd0, 3'b000, 1'b1, 5'd5, 5'd3, 5'd1, 32'd10, 32'd3, 32'd0, 2'd0, 2'd0);
        step();
        chk("sub_ctrl", 32'(aluctrl_o), 32'b1000);
        chk("sub_a", alu_a_o, 32'd10);
        chk("sub_b", alu_b_o, 32'd3);
        chk("sub_valid", 32'(ex_valid_o), 32'd1);

        // SRAI vs ADDI
        set_id(2'd1, 3'b101, 1'b1, 5'd5, 5'd0, 5'd2, 32'd10, 32'd0, 32'd4, 2'd0, 2'd1);
        step();
        chk("srai_ctrl", 32'(aluctrl_o), 32'b1101);
        chk("srai_b", alu_b_o, 32'd4);
        set_id(2'd1, 3'b000, 1'b1, 5'd5, 5'd0, 5'd2, 32'd10, 32'd0, 32'h400, 2'd0, 2'd1);
        step();
        chk("addi_ctrl", 32'(aluctrl_o), 32'b0000);

        // Forward priority
        set_id(2'd0, 3'b000, 1'b0, 5'd7, 5'd0, 5'd2, 32'h55, 32'd0, 32'd0, 2'd0, 2'd0);
        step();
        exmem_regwrite_i = 1; exmem_rd_addr_i = 7; exmem_result_i = 32'hAAAA;
        memwb_regwrite_i = 1; memwb_rd_addr_i = 7; memwb_result_i = 32'hBBBB;
        #1 chk("fwd_exmem", alu_a_o, 32'hAAAA);
        exmem_regwrite_i = 0;
        #1 chk("fwd_memwb", alu_a_o, 32'hBBBB);
        no_fwd();

        // x0 never forwarded
        set_id(2'd0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd2, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0);
        step();
        exmem_regwrite_i = 1; exmem_rd_addr_i = 0; exmem_result_i = 32'hFFFF;
        #1 chk("x0_a", alu_a_o, 32'd0);
        no_fwd();

        // Stall refresh: producer visible only in the first stall cycle
        set_id(2'd0, 3'b000, 1'b0, 5'd1, 5'd9, 5'd2, 32'd1, 32'd0, 32'd0, 2'd0, 2'd0);
        step();
        stall_i = 1;
        memwb_regwrite_i = 1; memwb_rd_addr_i = 9; memwb_result_i = 32'h1234;
        step();
        no_fwd();
        #1 chk("stall_c2", ex_store_data_o, 32'h1234);
        step();
        chk("stall_c3", ex_store_data_o, 32'h1234);

        // Flush together with stall
        flush_i = 1;
        set_id(2'd0, 3'b000, 1'b1, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2, 32'd0, 2'd0, 2'd0);
        step();
        chk("flush_valid", 32'(ex_valid_o), 32'd0);
        chk("flush_rw", 32'(ex_regwrite_o), 32'd0);
        chk("flush_ctrl", 32'(aluctrl_o), 32'd0);
        flush_i = 0;

        // Reset while stalled
        stall_i = 0;
        step();
        stall_i = 1; rst = 1;
        step();
        chk("rst_stall_valid", 32'(ex_valid_o), 32'd0);
        rst = 0; stall_i = 0;

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 40) == 0);
            flush_i    = ($urandom_range(0, 7) == 0);
            stall_i    = ($urandom_range(0, 3) == 0);
            id_valid_i = ($urandom_range(0, 5) != 0);
            id_pc_i = $urandom; id_imm_i = $urandom;
            id_rs1_data_i = $urandom; id_rs2_data_i = $urandom;
            id_rs1_addr_i = 5'($urandom_range(0, 3));
            id_rs2_addr_i = 5'($urandom_range(0, 3));
            id_rd_addr_i  = 5'($urandom_range(0, 31));
            id_regwrite_i = 1'($urandom_range(0, 1));
            id_funct3_i   = 3'($urandom_range(0, 7));
            id_funct7b5_i = 1'($urandom_range(0, 1));
            id_op_kind_i  = 2'($urandom_range(0, 3));
            id_src_a_i    = 2'($urandom_range(0, 3));
            id_src_b_i    = 2'($urandom_range(0, 3));
            exmem_regwrite_i = 1'($urandom_range(0, 1));
            exmem_rd_addr_i  = 5'($urandom_range(0, 3));
            exmem_result_i   = $urandom;
            memwb_regwrite_i = 1'($urandom_range(0, 1));
            memwb_rd_addr_i  = 5'($urandom_range(0, 3));
            memwb_result_i   = $urandom;
            step();
            exmem_regwrite_i = 1'($urandom_range(0, 1));
            exmem_rd_addr_i  = 5'($urandom_range(0, 3));
            exmem_result_i   = $urandom;
            memwb_regwrite_i = 1'($urandom_range(0, 1));
            memwb_rd_addr_i  = 5'($urandom_range(0, 3));
            memwb_result_i   = $urandom;
            #1 check_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
